game_mode_ctrl: RTL and testbench
=================================

// Module: game_mode_ctrl
// PURPOSE
//  Top-level game-mode sequencer for the tile-matching game: MENU -> INGAME -> ENDGAME -> LEADERBOARD -> MENU.
//  Adds multi-level play, win/lose tracking, timed end/leaderboard screens and an optional PAUSE mode.
//  Sits between the key/switch inputs and the in-game datapath.
//  Drives ingameOn to the game logic, and drives the mode/level/HEX outputs to the VGA and 7-seg blocks.
// PARAMETERS
//  LEVEL_W         3    width of level counter
//  NUM_LEVELS      4    levels per game, 1..2**LEVEL_W; clearing level NUM_LEVELS-1 is a win
//  END_HOLD_CYC    100_000_000  cycles ENDGAME is shown before LEADERBOARD (2 s @ 50 MHz)
//  LB_HOLD_CYC     250_000_000  cycles LEADERBOARD is shown before auto-return to MENU
//  CNT_W           28   hold-counter width; must hold max(END_HOLD_CYC, LB_HOLD_CYC)
// PORTS
//  CLOCK_50     in   1        system clock, 50 MHz
//  resetn       in   1        asynchronous active-low reset
//  userquit     in   1        synchronous quit; level-sensitive
//  keytobegin   in   1        start/confirm key, active-high level; rising edge detected internally
//  key_pause    in   1        pause toggle, active-high level; rising edge detected; ignored unless GAME_MODE_PAUSE_EN
//  level_clear  in   1        1-cycle pulse from game logic: current level completed
//  gameOver     in   1        1-cycle pulse from game logic: player lost
//  ingameOn     out  1        1 while in INGAME (0 in PAUSE)
//  mode_code    out  4        MENU 4'b0000, INGAME 4'b0011, ENDGAME 4'b0101, LEADERBOARD 4'b1001, PAUSE 4'b0110
//  level        out  LEVEL_W  current level, 0-based
//  win          out  1        valid in ENDGAME/LEADERBOARD: 1 = all levels cleared, 0 = lost/quit
//  level_start  out  1        1-cycle pulse when a level begins (entry to INGAME from MENU or on level advance)
//  hex0holder   out  7        active-low 7-seg glyph of mode digit: MENU 0, INGAME 1, END 2, LB 3, PAUSE 4
// BEHAVIOUR
//  - Reset (resetn=0, async):
//    - state=MENU, hold counter=0, edge-detect regs=0
//    - ingameOn=0, mode_code=4'b0000, level=0, win=0, level_start=0, hex0holder=7'b1000000
//  - All outputs registered; they reflect the new state one cycle after the transition-causing edge/pulse.
//  - Edge detect: kb_rise = keytobegin & ~kb_q; same for key_pause. kb_q/kp_q update every cycle.
//  - Priority per cycle: resetn > userquit > gameOver > level_clear > key edges > hold timeout.
//  - userquit=1: next state=MENU, level=0, win=0, counter=0. Holds MENU while asserted.
//  - MENU: kb_rise -> INGAME; level<=0; win<=0; level_start=1.
//  - INGAME:
//    - gameOver -> ENDGAME, win<=0.
//    - level_clear && level==NUM_LEVELS-1 -> ENDGAME, win<=1; level holds.
//    - level_clear otherwise -> stay INGAME; level<=level+1; level_start=1.
//    - gameOver && level_clear in the same cycle -> lose (gameOver wins).
//  - ENDGAME:
//    - counter increments each cycle.
//    - When counter==END_HOLD_CYC-1 -> LEADERBOARD, counter<=0.
//    - kb_rise ignored.
//  - LEADERBOARD:
//    - kb_rise -> MENU, counter<=0.
//    - else counter==LB_HOLD_CYC-1 -> MENU, counter<=0.
//    - level/win hold until MENU->INGAME.
//  - Counter is cleared on every state entry; it never wraps (it stops at a transition).
//  - level_clear/gameOver outside INGAME are ignored.
//  - An unused state encoding -> MENU next cycle.
// CONFIGURATION
//  GAME_MODE_PAUSE_EN defined:
//    - INGAME + kp_rise -> PAUSE (ingameOn=0); PAUSE + kp_rise -> INGAME with level unchanged, no level_start.
//    - In PAUSE, gameOver/level_clear are ignored; userquit -> MENU.
//  GAME_MODE_PAUSE_EN undefined:
//    - No PAUSE state; key_pause unused.
//    - mode_code never equals 4'b0110.
// TESTING  (bench params: NUM_LEVELS=3, END_HOLD_CYC=5, LB_HOLD_CYC=8)
//  1. resetn low mid-INGAME at level 2 -> same cycle: mode_code=0, level=0, ingameOn=0, hex0holder=7'b1000000.
//  2. Hold keytobegin high 10 cycles in MENU -> exactly one transition to INGAME.
//     One level_start pulse; ingameOn=1 one cycle after the first edge.
//  3. Three level_clear pulses from MENU start -> level 0->1->2, then ENDGAME with win=1.
//     LEADERBOARD 5 cycles later; MENU 8 cycles after that.
//  4. gameOver and level_clear in the same cycle at level 0 -> ENDGAME, win=0, level=0.
//  5. userquit and keytobegin rise in the same cycle in MENU -> stays MENU.
//     userquit in LEADERBOARD -> MENU next cycle.
//  6. (GAME_MODE_PAUSE_EN) key_pause edge at level 1 -> PAUSE, mode_code=4'b0110, ingameOn=0.
//     gameOver during PAUSE ignored; second key_pause edge -> INGAME, level=1, no level_start.

Source files
------------

// File: rtl/game_mode_ctrl_if.sv
// Key/switch and game-logic strobes into the mode sequencer, mode/level/7-seg status out of it.
// master = sequencer side, slave = the surrounding board logic that feeds it.
interface game_mode_ctrl_if #(
    parameter int LEVEL_W = 3
) ();
    logic               userquit;
    logic               keytobegin;
    logic               key_pause;
    logic               level_clear;
    logic               gameOver;
    logic               ingameOn;
    logic [3:0]         mode_code;
    logic [LEVEL_W-1:0] level;
    logic               win;
    logic               level_start;
    logic [6:0]         hex0holder;

    modport master (
        input  userquit, keytobegin, key_pause, level_clear, gameOver,
        output ingameOn, mode_code, level, win, level_start, hex0holder
    );

    modport slave (
        output userquit, keytobegin, key_pause, level_clear, gameOver,
        input  ingameOn, mode_code, level, win, level_start, hex0holder
    );
endinterface

// File: rtl/game_mode_ctrl.sv
// Game-mode sequencer MENU->INGAME->ENDGAME->LEADERBOARD->MENU; optional PAUSE under GAME_MODE_PAUSE_EN.
// All outputs registered: they change one cycle after the causing key edge / pulse; no backpressure.
module game_mode_ctrl #(
    parameter int LEVEL_W      = 3,
    parameter int NUM_LEVELS   = 4,
    parameter int END_HOLD_CYC = 100_000_000,
    parameter int LB_HOLD_CYC  = 250_000_000,
    parameter int CNT_W        = 28
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    game_mode_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_MENU   = 3'd0,
        S_INGAME = 3'd1,
        S_END    = 3'd2,
        S_LB     = 3'd3
`ifdef GAME_MODE_PAUSE_EN
        , S_PAUSE = 3'd4
`endif
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [LEVEL_W-1:0] level_q, level_nxt;
    logic               win_q, win_nxt;
    logic               start_q, start_nxt;
    logic               ingame_q;
    logic [3:0]         mode_q;
    logic [6:0]         hex_q;
    logic               kb_q, kb_rise;
    logic               kp_q, kp_rise;

    assign kb_rise = bus.keytobegin & ~kb_q;
`ifdef GAME_MODE_PAUSE_EN
    assign kp_rise = bus.key_pause & ~kp_q;
`else
    logic unused_key_pause;
    assign unused_key_pause = bus.key_pause;
    assign kp_rise          = 1'b0;
`endif

    function automatic logic [3:0] mode_of(input state_t s);
        case (s)
            S_INGAME: mode_of = 4'b0011;
            S_END:    mode_of = 4'b0101;
            S_LB:     mode_of = 4'b1001;
`ifdef GAME_MODE_PAUSE_EN
            S_PAUSE:  mode_of = 4'b0110;
`endif
            default:  mode_of = 4'b0000;
        endcase
    endfunction

    // Active-low segments (g..a) for the mode digit 0..4.
    function automatic logic [6:0] hex_of(input state_t s);
        case (s)
            S_INGAME: hex_of = 7'b1111001;
            S_END:    hex_of = 7'b0100100;
            S_LB:     hex_of = 7'b0110000;
`ifdef GAME_MODE_PAUSE_EN
            S_PAUSE:  hex_of = 7'b0011001;
`endif
            default:  hex_of = 7'b1000000;
        endcase
    endfunction

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        level_nxt = level_q;
        win_nxt   = win_q;
        start_nxt = 1'b0;
        if (bus.userquit) begin
            state_nxt = S_MENU;
            cnt_nxt   = '0;
            level_nxt = '0;
            win_nxt   = 1'b0;
        end else begin
            case (state_q)
                S_MENU: begin
                    if (kb_rise) begin
                        state_nxt = S_INGAME;
                        cnt_nxt   = '0;
                        level_nxt = '0;
                        win_nxt   = 1'b0;
                        start_nxt = 1'b1;
                    end
                end
                S_INGAME: begin
                    // A loss reported together with a clear still counts as a loss.
                    if (bus.gameOver) begin
                        state_nxt = S_END;
                        cnt_nxt   = '0;
                        win_nxt   = 1'b0;
                    end else if (bus.level_clear) begin
                        if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
                            state_nxt = S_END;
                            cnt_nxt   = '0;
                            win_nxt   = 1'b1;
                        end else begin
                            level_nxt = level_q + LEVEL_W'(1);
                            start_nxt = 1'b1;
                        end
                    end else if (kp_rise) begin
`ifdef GAME_MODE_PAUSE_EN
                        state_nxt = S_PAUSE;
                        cnt_nxt   = '0;
`endif
                    end
                end
                S_END: begin
                    if (cnt_q == CNT_W'(END_HOLD_CYC - 1)) begin
                        state_nxt = S_LB;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                S_LB: begin
                    if (kb_rise || cnt_q == CNT_W'(LB_HOLD_CYC - 1)) begin
                        state_nxt = S_MENU;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
`ifdef GAME_MODE_PAUSE_EN
                S_PAUSE: begin
                    if (kp_rise) begin
                        state_nxt = S_INGAME;
                        cnt_nxt   = '0;
                    end
                end
`endif
                default: begin
                    state_nxt = S_MENU;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_MENU;
            cnt_q    <= '0;
            kb_q     <= 1'b0;
            kp_q     <= 1'b0;
            level_q  <= '0;
            win_q    <= 1'b0;
            start_q  <= 1'b0;
            ingame_q <= 1'b0;
            mode_q   <= 4'b0000;
            hex_q    <= 7'b1000000;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            kb_q     <= bus.keytobegin;
            kp_q     <= bus.key_pause;
            level_q  <= level_nxt;
            win_q    <= win_nxt;
            start_q  <= start_nxt;
            ingame_q <= (state_nxt == S_INGAME);
            mode_q   <= mode_of(state_nxt);
            hex_q    <= hex_of(state_nxt);
        end
    end

    assign bus.ingameOn    = ingame_q;
    assign bus.mode_code   = mode_q;
    assign bus.level       = level_q;
    assign bus.win         = win_q;
    assign bus.level_start = start_q;
    assign bus.hex0holder  = hex_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Randomised + directed bench for game_mode_ctrl; a per-cycle reference model feeds a scoreboard queue.
module tb_game_mode_ctrl;
    localparam int LEVEL_W    = 3;
    localparam int NUM_LEVELS = 3;
    localparam int END_HOLD   = 5;
    localparam int LB_HOLD    = 8;
    localparam int CNT_W      = 4;

    localparam int M_MENU = 0, M_GAME = 1, M_END = 2, M_LB = 3, M_PAUSE = 4;
    localparam logic [3:0] CODE_TAB [5] = '{4'b0000, 4'b0011, 4'b0101, 4'b1001, 4'b0110};
    localparam logic [6:0] HEX_TAB  [5] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;

    game_mode_ctrl_if #(.LEVEL_W(LEVEL_W)) bus ();

    game_mode_ctrl #(
        .LEVEL_W(LEVEL_W), .NUM_LEVELS(NUM_LEVELS),
        .END_HOLD_CYC(END_HOLD), .LB_HOLD_CYC(LB_HOLD), .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [3:0]         mode;
        logic [LEVEL_W-1:0] level;
        logic               win;
        logic               ingame;
        logic               start;
        logic [6:0]         hex;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: which screen we are on and how long we have been there.
    int m_mode, m_level, m_timer;
    bit m_win, m_start, m_kb_prev, m_kp_prev;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.mode   = CODE_TAB[m_mode];
        e.hex    = HEX_TAB[m_mode];
        e.level  = LEVEL_W'(m_level);
        e.win    = m_win;
        e.ingame = (m_mode == M_GAME);
        e.start  = m_start;
        return e;
    endfunction

    task automatic enter(input int mode);
        m_mode  = mode;
        m_timer = 0;
    endtask

    task automatic model_reset();
        enter(M_MENU);
        m_level = 0; m_win = 0; m_start = 0; m_kb_prev = 0; m_kp_prev = 0;
    endtask

    task automatic model_step(input bit quit, input bit kb, input bit kp, input bit lc, input bit go);
        bit kb_edge, kp_edge;
        kb_edge   = kb && !m_kb_prev;
        kp_edge   = kp && !m_kp_prev;
        m_kb_prev = kb;
        m_kp_prev = kp;
        m_start   = 0;
        if (quit) begin
            enter(M_MENU); m_level = 0; m_win = 0;
        end else begin
            case (m_mode)
                M_MENU: if (kb_edge) begin
                    enter(M_GAME); m_level = 0; m_win = 0; m_start = 1;
                end
                M_GAME: begin
                    if (go) begin
                        enter(M_END); m_win = 0;
                    end else if (lc) begin
                        if (m_level == NUM_LEVELS - 1) begin
                            enter(M_END); m_win = 1;
                        end else begin
                            m_level++; m_start = 1;
                        end
                    end
`ifdef GAME_MODE_PAUSE_EN
                    else if (kp_edge) enter(M_PAUSE);
`endif
                end
                M_END: begin
                    m_timer++;
                    if (m_timer == END_HOLD) enter(M_LB);
                end
                M_LB: begin
                    m_timer++;
                    if (kb_edge || m_timer == LB_HOLD) enter(M_MENU);
                end
                M_PAUSE: if (kp_edge) enter(M_GAME);
                default: enter(M_MENU);
            endcase
        end
    endtask

    // One clock of stimulus; its expected result is due at the next falling edge.
    task automatic drive(input bit quit, input bit kb, input bit kp, input bit lc, input bit go);
        @(negedge CLOCK_50);
        #1;
        resetn          = 1'b1;
        bus.userquit    = quit;
        bus.keytobegin  = kb;
        bus.key_pause   = kp;
        bus.level_clear = lc;
        bus.gameOver    = go;
        model_step(quit, kb, kp, lc, go);
        sb_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic start_game();
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic hard_reset();
        exp_t e;
        @(negedge CLOCK_50);
        #1;
        resetn          = 1'b0;
        bus.userquit    = 0; bus.keytobegin = 0; bus.key_pause = 0;
        bus.level_clear = 0; bus.gameOver   = 0;
        model_reset();
        e = model_out();
        #1;
        check("rst_mode",   bus.mode_code,  e.mode);
        check("rst_level",  bus.level,      e.level);
        check("rst_ingame", bus.ingameOn,   e.ingame);
        check("rst_hex",    bus.hex0holder, e.hex);
        check("rst_win",    bus.win,        e.win);
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("mode_code",   bus.mode_code,   e.mode);
                check("level",       bus.level,       e.level);
                check("win",         bus.win,         e.win);
                check("ingameOn",    bus.ingameOn,    e.ingame);
                check("level_start", bus.level_start, e.start);
                check("hex0holder",  bus.hex0holder,  e.hex);
            end
        end
    end

    initial begin : stimulus
        bus.userquit = 0; bus.keytobegin = 0; bus.key_pause = 0;
        bus.level_clear = 0; bus.gameOver = 0;
        hard_reset();

        // key held high for 10 cycles: single start
        idle(2);
        repeat (10) drive(0, 1, 0, 0, 0);
        idle(1);
        // three clears -> win, then timed ENDGAME and LEADERBOARD
        repeat (3) begin
            drive(0, 0, 0, 1, 0);
            idle(2);
        end
        idle(16);
        // simultaneous loss and clear at level 0
        start_game();
        drive(0, 0, 0, 1, 1);
        idle(16);
        // quit beats start in MENU; quit from LEADERBOARD
        drive(1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        idle(1);
        start_game();
        drive(0, 0, 0, 0, 1);
        idle(7);
        drive(1, 0, 0, 0, 0);
        idle(2);
        // pause toggles at level 1 with a loss pulse in between
        start_game();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0);
        idle(2);
        drive(1, 0, 0, 0, 0);
        // async reset while playing level 2
        start_game();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        idle(1);
        hard_reset();
        idle(1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) hard_reset();
            else drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 14) == 0);
        end
        idle(1);

        @(negedge CLOCK_50);
        #2;
        check("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
